// File: rtl/byte_rx_pkg.sv
// byte_rx_pkg: shared types and width helpers for the serial byte receiver.
//   state_e          - receiver FSM states
//   IDX_W            - width of the data bit index (8 data bits)
//   CLKS_PER_BIT_DEF - default oversampling ratio
//   cnt_width()      - bit-counter width for a given CLKS_PER_BIT
package byte_rx_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StBreak  = 3'd5
   } state_e;

   localparam int unsigned IDX_W            = 3;
   localparam int unsigned CLKS_PER_BIT_DEF = 16;

   // Counter holds values up to CLKS_PER_BIT-1.
   function automatic int unsigned cnt_width(input int unsigned clks);
      return (clks < 2) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/byte_rx_if.sv
// byte_rx_if: serial line plus received-byte outputs of byte_rx.
//   rxd        - serial line, idle high
//   data       - last good byte
//   enable     - one-cycle strobe when data is new
//   busy       - frame in progress
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, parity mismatch
// master: the line driver / byte consumer side. slave: the receiver.
interface byte_rx_if;

   logic       rxd;
   logic [7:0] data;
   logic       enable;
   logic       busy;
   logic       frame_err;
   logic       parity_err;

   modport master (
      output rxd,
      input  data, enable, busy, frame_err, parity_err
   );

   modport slave (
      input  rxd,
      output data, enable, busy, frame_err, parity_err
   );

endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
//   clk  - destination clock
//   rst_ - asynchronous active-low reset, both flops load RST_VAL
//   d    - asynchronous input
//   q    - synchronized output
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/byte_rx.sv
// byte_rx: oversampling asynchronous-serial byte receiver.
// Deframes start / 8 data (LSB first) / optional parity / stop, and strobes
// validated bytes into data with a one-cycle enable. Faulty frames raise
// frame_err or parity_err instead and leave data untouched.
//   clk  - clock
//   rst_ - asynchronous active-low reset
//   bus  - byte_rx_if.slave (rxd in; data, enable, busy, frame_err, parity_err out)
module byte_rx
   import byte_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter bit          PARITY_EN    = 1'b1,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic     clk,
   input  logic     rst_,
   byte_rx_if.slave bus
);

   localparam int unsigned   CW      = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             par_bad_q, par_bad_d;  // parity verdict held until stop
   logic             enable_q, enable_d;
   logic             ferr_q, ferr_d;
   logic             perr_q, perr_d;
   logic             rxd_prev_q;
   // Edge detection is held off until the synchronizer has flushed its reset
   // value, so a line that is already low at release is not taken as a start.
   logic [1:0]       settle_q, settle_d;

   logic rxd_s;
   logic expired;
   logic fall;

   sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk  (clk),
      .rst_ (rst_),
      .d    (bus.rxd),
      .q    (rxd_s)
   );

   assign expired = (cnt_q == '0);
   assign fall    = (settle_q == 2'd3) && rxd_prev_q && !rxd_s;

   // State register (all state lives here).
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         par_bad_q  <= 1'b0;
         enable_q   <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         rxd_prev_q <= 1'b1;
         settle_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         par_bad_q  <= par_bad_d;
         enable_q   <= enable_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         rxd_prev_q <= rxd_s;
         settle_q   <= settle_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = expired ? cnt_q : cnt_q - 1'b1;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      par_bad_d = par_bad_q;
      enable_d  = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;
      settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            if (fall) begin
               state_d   = StStart;
               cnt_d     = HALF_M1;
               par_bad_d = 1'b0;
            end
         end
         StStart: begin
            if (expired) begin
               if (!rxd_s) begin
                  state_d = StData;
                  cnt_d   = FULL_M1;
                  idx_d   = '0;
               end else begin
                  state_d = StIdle;  // glitch, not a real start bit
               end
            end
         end
         StData: begin
            if (expired) begin
               shift_d = {rxd_s, shift_q[7:1]};
               cnt_d   = FULL_M1;
               idx_d   = idx_q + 1'b1;
               if (&idx_q) begin
                  state_d = PARITY_EN ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (expired) begin
               par_bad_d = ((^shift_q) ^ rxd_s) != PARITY_ODD;
               cnt_d     = FULL_M1;
               state_d   = StStop;
            end
         end
         StStop: begin
            // Leaving at mid-stop lets a start edge half a bit later be caught.
            if (expired) begin
               if (!rxd_s) begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end else if (par_bad_q) begin
                  perr_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  data_d   = shift_q;
                  enable_d = 1'b1;
                  state_d  = StIdle;
               end
            end
         end
         StBreak: begin
            if (rxd_s) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs, all taken from registers.
   always_comb begin
      bus.data       = data_q;
      bus.enable     = enable_q;
      bus.busy       = (state_q != StIdle);
      bus.frame_err  = ferr_q;
      bus.parity_err = perr_q;
   end

endmodule
